floo_axi_latency_pipe: RTL and testbench



---
 rtl/floo_test_pkg.sv | 15 +
 rtl/floo_latency_entry_buf.sv | 83 ++++++++
 rtl/floo_axi_latency_pipe.sv | 102 ++++++++++
 tb/tb_floo_axi_latency_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/floo_test_pkg.sv
// Shared constants for the floo test infrastructure: default HBM pipe latency and stats sizing.
package floo_test_pkg;

   localparam int unsigned HbmPipeLatency = 8;
   localparam int unsigned StatsCntWidth  = 32;

   // Saturating increment for the stall statistics counters.
   function automatic logic [StatsCntWidth-1:0] stats_sat_inc(input logic [StatsCntWidth-1:0] cnt);
      if (&cnt) begin
         return cnt;
      end
      return cnt + StatsCntWidth'(1);
   endfunction

endpackage

// File: rtl/floo_latency_entry_buf.sv
// Circular entry store where every entry carries a saturating countdown to its release cycle.
module floo_latency_entry_buf #(
   parameter int unsigned Latency   = 8,
   parameter int unsigned Depth     = 16,
   parameter type         payload_t = logic
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  payload_t data_i,
   input  logic     pop_i,
   output payload_t head_data_o,
   output logic     head_ripe_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int unsigned CntWidth = $clog2(Latency + 1);
   localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

   typedef logic [CntWidth-1:0] cnt_t;
   typedef struct packed {
      logic                wrap;
      logic [IdxWidth-1:0] idx;
   } ptr_t;

   payload_t data_q [Depth];
   cnt_t     cnt_q  [Depth];
   ptr_t     wr_q;
   ptr_t     rd_q;

   // Index wraps at Depth-1 so non-power-of-two depths work; the wrap bit flips on each lap.
   function automatic ptr_t ptr_next(input ptr_t p);
      ptr_t r;
      if (p.idx == IdxWidth'(Depth - 1)) begin
         r.idx  = '0;
         r.wrap = ~p.wrap;
      end else begin
         r.idx  = p.idx + IdxWidth'(1);
         r.wrap = p.wrap;
      end
      return r;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) begin
            wr_q <= ptr_next(wr_q);
         end
         if (pop_i) begin
            rd_q <= ptr_next(rd_q);
         end
      end
   end

   // Free slots may keep aging harmlessly; a push always reloads the full countdown.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
         if (rst_i) begin
            cnt_q[i] <= '0;
         end else if (push_i && (wr_q.idx == IdxWidth'(i))) begin
            cnt_q[i] <= CntWidth'(Latency - 1);
         end else if (cnt_q[i] != '0) begin
            cnt_q[i] <= cnt_q[i] - CntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         data_q[wr_q.idx] <= data_i;
      end
   end

   assign empty_o     = (wr_q == rd_q);
   assign full_o      = (wr_q.idx == rd_q.idx) && (wr_q.wrap != rd_q.wrap);
   assign head_data_o = data_q[rd_q.idx];
   assign head_ripe_o = (cnt_q[rd_q.idx] == '0);

endmodule

// File: rtl/floo_axi_latency_pipe.sv
// Fixed-latency, full-throughput valid/ready delay stage for one AXI channel.
// Optional stall counters enabled with FLOO_AXI_LATENCY_PIPE_STATS_EN.
module floo_axi_latency_pipe
   import floo_test_pkg::*;
#(
   parameter int unsigned Latency   = HbmPipeLatency,
   parameter int unsigned Depth     = 16,
   parameter type         payload_t = logic
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  payload_t                   data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output payload_t                   data_o,
   output logic [$clog2(Depth+1)-1:0] occupancy_o
`ifdef FLOO_AXI_LATENCY_PIPE_STATS_EN
   ,
   output logic [StatsCntWidth-1:0]   stall_in_cnt_o,
   output logic [StatsCntWidth-1:0]   stall_out_cnt_o
`endif
);

   localparam int unsigned OccWidth = $clog2(Depth + 1);

   if ((Latency < 1) || (Latency > 255)) begin : gen_latency_chk
      $error("floo_axi_latency_pipe: Latency must be in 1..255");
   end
   if (Depth < Latency) begin : gen_depth_chk
      $error("floo_axi_latency_pipe: Depth must be >= Latency for full throughput");
   end

   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic                head_ripe;
   logic [OccWidth-1:0] occ_q;

   floo_latency_entry_buf #(
      .Latency   (Latency),
      .Depth     (Depth),
      .payload_t (payload_t)
   ) i_entry_buf (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .data_i      (data_i),
      .pop_i       (pop),
      .head_data_o (data_o),
      .head_ripe_o (head_ripe),
      .full_o      (full),
      .empty_o     (empty)
   );

   // Ready depends only on stored state, never on ready_i; no bypass when full.
   assign ready_o = !full && !rst_i;
   assign valid_o = !empty && head_ripe && !rst_i;
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q <= '0;
      end else if (push && !pop) begin
         occ_q <= occ_q + OccWidth'(1);
      end else if (pop && !push) begin
         occ_q <= occ_q - OccWidth'(1);
      end
   end

   assign occupancy_o = occ_q;

`ifdef FLOO_AXI_LATENCY_PIPE_STATS_EN
   logic [StatsCntWidth-1:0] stall_in_q;
   logic [StatsCntWidth-1:0] stall_out_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_in_q  <= '0;
         stall_out_q <= '0;
      end else begin
         if (valid_i && !ready_o) begin
            stall_in_q <= stats_sat_inc(stall_in_q);
         end
         if (valid_o && !ready_i) begin
            stall_out_q <= stats_sat_inc(stall_out_q);
         end
      end
   end

   assign stall_in_cnt_o  = stall_in_q;
   assign stall_out_cnt_o = stall_out_q;

   final begin
      $display("floo_axi_latency_pipe %m: stall_in=%0d stall_out=%0d", stall_in_q, stall_out_q);
   end
`endif

endmodule

// File: tb/tb_floo_axi_latency_pipe.sv
// Directed bench for floo_axi_latency_pipe: L=8/D=16 instance plus an L=3/D=5 wrap instance.
module tb_floo_axi_latency_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic       rst;
   logic       vi, ri, ro, vo;
   logic [7:0] di, dout;
   logic [4:0] occ;

   logic       v2, r2, rdy2, val2;
   logic [7:0] d2, dat2;
   logic [2:0] occ2;

`ifdef FLOO_AXI_LATENCY_PIPE_STATS_EN
   logic [31:0] sin, sout;
   logic [31:0] sin2, sout2;
`endif

   floo_axi_latency_pipe #(
      .Latency(8), .Depth(16), .payload_t(logic [7:0])
   ) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(vi), .ready_o(ro), .data_i(di),
      .valid_o(vo), .ready_i(ri), .data_o(dout), .occupancy_o(occ)
`ifdef FLOO_AXI_LATENCY_PIPE_STATS_EN
      , .stall_in_cnt_o(sin), .stall_out_cnt_o(sout)
`endif
   );

   floo_axi_latency_pipe #(
      .Latency(3), .Depth(5), .payload_t(logic [7:0])
   ) dut5 (
      .clk_i(clk), .rst_i(rst), .valid_i(v2), .ready_o(rdy2), .data_i(d2),
      .valid_o(val2), .ready_i(r2), .data_o(dat2), .occupancy_o(occ2)
`ifdef FLOO_AXI_LATENCY_PIPE_STATS_EN
      , .stall_in_cnt_o(sin2), .stall_out_cnt_o(sout2)
`endif
   );

   typedef struct {
      logic       vi;
      logic [7:0] di;
      logic       ri;
      logic       ev;
      logic [7:0] ed;
      logic       er;
      int         eo;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      int         c;
   } ent_t;

   vec_t tbl [10];
   ent_t q [$];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   int p, rx;
   logic prev_v, prev_pop;
   logic [7:0] prev_d;
   ent_t e;

   initial begin
      // single-beat latency vector: push 0xA5 in row 0, release in row 8
      tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 0};
      for (int i = 1; i < 8; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 1};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0};

      rst = 1'b1; vi = 1'b0; ri = 1'b1; di = '0;
      v2 = 1'b0; r2 = 1'b0; d2 = '0;

      tick(); sample();
      chk("rst_valid", int'(vo), 0);
      chk("rst_ready", int'(ro), 0);
      tick(); sample();
      chk("rst_occ", int'(occ), 0);
      tick(); rst = 1'b0; sample();
      chk("post_rst_ready", int'(ro), 1);
      chk("post_rst_valid", int'(vo), 0);
      chk("post_rst_occ", int'(occ), 0);

      for (int i = 0; i < 10; i++) begin
         tick();
         vi = tbl[i].vi; di = tbl[i].di; ri = tbl[i].ri;
         sample();
         chk($sformatf("tbl%0d_valid", i), int'(vo), int'(tbl[i].ev));
         chk($sformatf("tbl%0d_ready", i), int'(ro), int'(tbl[i].er));
         chk($sformatf("tbl%0d_occ", i), int'(occ), tbl[i].eo);
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), int'(dout), int'(tbl[i].ed));
      end

      // streaming: 100 back-to-back beats, each out exactly 8 cycles later
      rx = 0;
      for (int i = 0; i < 111; i++) begin
         tick();
         vi = (i < 100); di = 8'(i); ri = 1'b1;
         sample();
         if (vi) chk("stream_ready", int'(ro), 1);
         if (vo) begin
            chk("stream_data", int'(dout), rx);
            chk("stream_cycle", i, rx + 8);
            rx++;
         end
      end
      chk("stream_count", rx, 100);
      chk("stream_occ_end", int'(occ), 0);

      // backpressure: fill with ready_i low, then drain
      p = 0; rx = 0;
      for (int r = 0; r < 24; r++) begin
         tick();
         ri = 1'b0; vi = (p < 20); di = 8'(p);
         sample();
         if (vi && ro) p++;
         if (r >= 8) begin
            chk("bp_hold_valid", int'(vo), 1);
            chk("bp_hold_data", int'(dout), 0);
         end
      end
      chk("bp_pushed", p, 16);
      chk("bp_full_ready", int'(ro), 0);
      chk("bp_full_occ", int'(occ), 16);
      for (int d = 0; d < 40; d++) begin
         tick();
         ri = 1'b1; vi = (p < 20); di = 8'(p);
         sample();
         if (vi && ro) p++;
         if (rx < 20) begin
            chk("bp_drain_valid", int'(vo), 1);
            if (vo) begin
               chk("bp_drain_data", int'(dout), rx);
               rx++;
            end
         end else begin
            chk("bp_drain_idle", int'(vo), 0);
         end
      end
      chk("bp_drain_count", rx, 20);
      chk("bp_push_count", p, 20);
      chk("bp_occ_end", int'(occ), 0);

      // reset with 6 beats in flight
      for (int r = 0; r < 6; r++) begin
         tick();
         ri = 1'b0; vi = 1'b1; di = 8'(8'h60 + r);
         sample();
      end
      tick(); vi = 1'b0; rst = 1'b1; sample();
      chk("midrst_valid", int'(vo), 0);
      chk("midrst_ready", int'(ro), 0);
      tick(); rst = 1'b0; vi = 1'b1; di = 8'h3C; ri = 1'b1; sample();
      chk("afterrst_valid", int'(vo), 0);
      chk("afterrst_occ", int'(occ), 0);
      chk("afterrst_ready", int'(ro), 1);
      for (int r = 1; r < 13; r++) begin
         tick(); vi = 1'b0; sample();
         if (r == 8) begin
            chk("afterrst_beat_valid", int'(vo), 1);
            chk("afterrst_beat_data", int'(dout), 8'h3C);
         end else begin
            chk("afterrst_no_old", int'(vo), 0);
         end
      end

      // Depth=5 / Latency=3 with random downstream ready, across pointer wrap
      p = 0; rx = 0; prev_v = 1'b0; prev_pop = 1'b0; prev_d = '0;
      for (int r = 0; r < 600; r++) begin
         tick();
         r2 = 1'($urandom_range(0, 1)); v2 = (p < 50); d2 = 8'(p);
         sample();
         if (prev_v && !prev_pop) begin
            chk("d5_hold_valid", int'(val2), 1);
            chk("d5_hold_data", int'(dat2), int'(prev_d));
         end
         if (val2 && r2) begin
            chk("d5_not_spurious", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("d5_data", int'(dat2), int'(e.d));
               chk("d5_min_latency", int'(cyc >= e.c + 3), 1);
            end
            rx++;
         end
         if (v2 && rdy2) begin
            q.push_back('{d2, cyc});
            p++;
         end
         prev_v = val2; prev_pop = val2 && r2; prev_d = dat2;
         if (rx == 50) break;
      end
      chk("d5_count", rx, 50);
      chk("d5_queue_empty", q.size(), 0);
      v2 = 1'b0; r2 = 1'b1;

`ifdef FLOO_AXI_LATENCY_PIPE_STATS_EN
      tick(); rst = 1'b1; vi = 1'b0; sample();
      tick(); rst = 1'b0; sample();
      chk("stats_clear", int'(sout), 0);
      for (int r = 0; r < 22; r++) begin
         tick();
         vi = (r == 0); di = 8'h11; ri = (r >= 20);
         sample();
      end
      chk("stats_stall_out", int'(sout), 12);
      chk("stats_stall_in", int'(sin), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
